// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
//   Control FSM for the single-round, byte-serial AES datapath. It walks the
//   datapath through one full encryption (NR rounds), fetches each round key
//   from the key-schedule store with a level request / valid handshake, and
//   presents the ciphertext to the CTR wrapper with a valid/ready handshake.
//
// Parameters
//   NR        : number of rounds (10, 12 or 14; anything else fails elaboration)
//   WAIT_CODE : current_state code used while stalled for a round key
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : begin an encryption (sampled in IDLE only)
//   busy          : accepted block in flight, until the ciphertext handshake
//   key_req       : round key request (level)
//   key_idx       : index of the requested round key, 0..NR
//   key_vld       : requested round key is on the datapath key bus
//   current_state : datapath phase code
//   round         : current round, 0..NR
//   cnt           : byte / column index for the datapath
//   out_valid     : datapath state holds the ciphertext
//   out_ready     : consumer accepts the ciphertext
//   abort         : only with AES_ROUND_SEQ_ABORT_EN defined; drops the block
//
// Build option
//   AES_ROUND_SEQ_ABORT_EN : adds the abort input.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE  (0) | no block in flight, waiting for start
// ARK   (1) | AddRoundKey, single cycle
// SB    (2) | SubBytes, 16 cycles, cnt 15..0
// SR    (3) | ShiftRows, single cycle
// MC    (4) | MixColumns, 4 cycles, cnt 0..3 (skipped in the final round)
// WAIT  (*) | round key requested, held until key_vld
// DONE  (9) | final AddRoundKey written back, single cycle
// FINISH(10)| ciphertext presented, held until out_ready

module aes_round_sequencer #(
  parameter int unsigned NR        = 14,
  parameter logic [3:0]  WAIT_CODE = 4'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef AES_ROUND_SEQ_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       key_req,
  output logic [3:0] key_idx,
  input  logic       key_vld,
  output logic [3:0] current_state,
  output logic [3:0] round,
  output logic [4:0] cnt,
  output logic       out_valid,
  input  logic       out_ready
);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $error("aes_round_sequencer: NR must be 10, 12 or 14");
  end

  if (WAIT_CODE <= 4'd4 || WAIT_CODE == 4'd9 || WAIT_CODE == 4'd10) begin : g_bad_wait_code
    $error("aes_round_sequencer: WAIT_CODE collides with a datapath phase code");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ARK    = 4'd1,
    ST_SB     = 4'd2,
    ST_SR     = 4'd3,
    ST_MC     = 4'd4,
    ST_WAIT   = WAIT_CODE,
    ST_DONE   = 4'd9,
    ST_FINISH = 4'd10
  } state_t;

  state_t state;

  logic abort_i;
`ifdef AES_ROUND_SEQ_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // The state register is itself the phase code, so current_state is registered.
  assign current_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      round     <= 4'd0;
      cnt       <= 5'd0;
      key_req   <= 1'b0;
      key_idx   <= 4'd0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else if (abort_i && state != ST_IDLE) begin
      state     <= ST_IDLE;
      round     <= 4'd0;
      cnt       <= 5'd0;
      key_req   <= 1'b0;
      key_idx   <= 4'd0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          round <= 4'd0;
          cnt   <= 5'd0;
          // abort and start together in IDLE: the start is dropped
          if (start && !abort_i) begin
            state   <= ST_WAIT;
            key_req <= 1'b1;
            key_idx <= 4'd0;
            busy    <= 1'b1;
            cnt     <= 5'd6;
          end
        end
        ST_WAIT: begin
          cnt <= 5'd6;
          if (key_vld) begin
            state   <= ST_ARK;
            key_req <= 1'b0;
          end
        end
        ST_ARK: begin
          if (round != NR_L) begin
            round <= round + 4'd1;
            state <= ST_SB;
            cnt   <= 5'd15;
          end else begin
            state <= ST_DONE;
            cnt   <= 5'd0;
          end
        end
        ST_SB: begin
          if (cnt == 5'd0) begin
            state <= ST_SR;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        ST_SR: begin
          // final round has no MixColumns
          if (round != NR_L) begin
            state <= ST_MC;
            cnt   <= 5'd0;
          end else begin
            state   <= ST_WAIT;
            key_req <= 1'b1;
            key_idx <= round;
            cnt     <= 5'd6;
          end
        end
        ST_MC: begin
          if (cnt == 5'd3) begin
            state   <= ST_WAIT;
            key_req <= 1'b1;
            key_idx <= round;
            cnt     <= 5'd6;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        ST_DONE: begin
          state     <= ST_FINISH;
          out_valid <= 1'b1;
        end
        ST_FINISH: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            round     <= 4'd0;
            cnt       <= 5'd0;
            key_idx   <= 4'd0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          round     <= 4'd0;
          cnt       <= 5'd0;
          key_req   <= 1'b0;
          key_idx   <= 4'd0;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Testbench for aes_round_sequencer (NR=14, WAIT_CODE=5).
// Expected traces are built per encryption from the round structure
// (key wait / ARK / SB / SR / MC) and compared cycle by cycle.

module tb_aes_round_sequencer;

  localparam int NR = 14;
  localparam int WC = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       busy;
  logic       key_req;
  logic [3:0] key_idx;
  logic       key_vld;
  logic [3:0] current_state;
  logic [3:0] round;
  logic [4:0] cnt;
  logic       out_valid;
  logic       out_ready;

  always #5 clk = ~clk;

  aes_round_sequencer #(.NR(NR), .WAIT_CODE(4'd5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
`ifdef AES_ROUND_SEQ_ABORT_EN
    .abort         (abort),
`endif
    .busy          (busy),
    .key_req       (key_req),
    .key_idx       (key_idx),
    .key_vld       (key_vld),
    .current_state (current_state),
    .round         (round),
    .cnt           (cnt),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  typedef struct {
    logic [19:0] exp;
    logic        vld;
    logic        rdy;
  } step_t;

  typedef struct {
    int stall_round;
    int stall_len;
    int bp;
    int exp_ov_edge;
    int exp_idle_edge;
  } scen_t;

  step_t trace[$];
  int    vectors = 0;
  int    miscompares = 0;

  function automatic logic [19:0] pk(input int s, input int r, input int c, input int kr,
                                     input int ki, input int b, input int ov);
    return {4'(s), 4'(r), 5'(c), 1'(kr), 4'(ki), 1'(b), 1'(ov)};
  endfunction

  function automatic logic [19:0] actual();
    return {current_state, round, cnt, key_req, key_idx, busy, out_valid};
  endfunction

  function automatic int rnd_bit();
    return int'($urandom_range(0, 1));
  endfunction

  task automatic check(input string name, input int idx, input logic [19:0] act,
                       input logic [19:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s [%0d] got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int s, input int r, input int c, input int kr, input int ki,
                     input int b, input int ov, input int vld, input int rdy);
    step_t st;
    st.exp = pk(s, r, c, kr, ki, b, ov);
    st.vld = 1'(vld);
    st.rdy = 1'(rdy);
    trace.push_back(st);
  endtask

  // One encryption from the acceptance edge onward. stall[r] is the number of
  // extra cycles key_vld is held low in the wait before round r's AddRoundKey;
  // bp is the number of cycles out_ready is held low once the ciphertext is up.
  task automatic build_trace(input int stall[0:14], input int bp);
    trace.delete();
    for (int r = 0; r <= NR; r++) begin
      for (int i = 0; i <= stall[r]; i++)
        add(WC, r, 6, 1, r, 1, 0, (i == stall[r]) ? 1 : 0, rnd_bit());
      add(1, r, 6, 0, r, 1, 0, rnd_bit(), rnd_bit());
      if (r == NR) break;
      for (int c = 15; c >= 0; c--) add(2, r + 1, c, 0, r, 1, 0, rnd_bit(), rnd_bit());
      add(3, r + 1, 0, 0, r, 1, 0, rnd_bit(), rnd_bit());
      if (r + 1 < NR)
        for (int c = 0; c < 4; c++) add(4, r + 1, c, 0, r, 1, 0, rnd_bit(), rnd_bit());
    end
    add(9, NR, 0, 0, NR, 1, 0, rnd_bit(), rnd_bit());
    for (int i = 0; i <= bp; i++) add(10, NR, 0, 0, NR, 1, 1, rnd_bit(), (i == bp) ? 1 : 0);
    add(0, 0, 0, 0, 0, 0, 0, rnd_bit(), rnd_bit());
  endtask

  // Entered at posedge+#1 with the DUT idle. Extra start pulses are thrown in
  // while busy (always one at index 50); they must be ignored.
  task automatic run_trace(input string name, output int ov_edge, output int idle_edge);
    ov_edge   = -1;
    idle_edge = -1;
    start     = 1'b1;
    key_vld   = 1'(rnd_bit());
    out_ready = 1'(rnd_bit());
    for (int k = 0; k < trace.size(); k++) begin
      @(posedge clk);
      #1;
      check(name, k, actual(), trace[k].exp);
      if (out_valid && ov_edge < 0) ov_edge = k;
      if (ov_edge >= 0 && idle_edge < 0 && current_state == 4'd0) idle_edge = k;
      key_vld   = trace[k].vld;
      out_ready = trace[k].rdy;
      if (k + 1 == trace.size()) start = 1'b0;
      else if (k == 50)          start = 1'b1;
      else                       start = ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
  endtask

  task automatic wait_for(input int st, input int rd, input string name);
    int n;
    n = 0;
    while (!(current_state == 4'(st) && round == 4'(rd)) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_int(name, (n < 400) ? 1 : 0, 1);
  endtask

  scen_t scen[5];
  int    stall[0:14];
  int    ov_e, idle_e;

  initial begin
    scen[0] = '{-1, 0,  0, 321, 322};
    scen[1] = '{ 7, 5,  0, 326, 327};
    scen[2] = '{-1, 0, 10, 321, 332};
    scen[3] = '{ 0, 3,  0, 324, 325};
    scen[4] = '{14, 2,  4, 323, 328};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; key_vld = 1'b0; out_ready = 1'b0;
    #12;
    check("reset_state", 0, actual(), 20'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    key_vld = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold", 0, actual(), 20'h0);

    foreach (scen[i]) begin
      foreach (stall[r]) stall[r] = 0;
      if (scen[i].stall_round >= 0) stall[scen[i].stall_round] = scen[i].stall_len;
      build_trace(stall, scen[i].bp);
      run_trace($sformatf("scen%0d", i), ov_e, idle_e);
      check_int($sformatf("scen%0d_ov_edge", i), ov_e, scen[i].exp_ov_edge);
      check_int($sformatf("scen%0d_idle_edge", i), idle_e, scen[i].exp_idle_edge);
    end

    for (int n = 0; n < 4; n++) begin
      foreach (stall[r]) stall[r] = int'($urandom_range(0, 3));
      build_trace(stall, int'($urandom_range(0, 5)));
      run_trace($sformatf("rand%0d", n), ov_e, idle_e);
    end

    // Reset in the middle of round 3 SubBytes (cnt=9)
    key_vld = 1'b1; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int n;
      n = 0;
      while (!(current_state == 4'd2 && round == 4'd3 && cnt == 5'd9) && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      check_int("reach_sb_r3_cnt9", (n < 200) ? 1 : 0, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 0, actual(), 20'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    foreach (stall[r]) stall[r] = 0;
    build_trace(stall, 0);
    run_trace("post_reset", ov_e, idle_e);
    check_int("post_reset_ov_edge", ov_e, 321);

`ifdef AES_ROUND_SEQ_ABORT_EN
    key_vld = 1'b1; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_for(4, 5, "reach_mc_r5");
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle", 0, actual(), 20'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort_quiet", i, actual(), 20'h0);
    end
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", 0, actual(), 20'h0);
    build_trace(stall, 2);
    run_trace("post_abort", ov_e, idle_e);
    check_int("post_abort_ov_edge", ov_e, 321);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
